// File: rtl/exe_stage_pkg.sv
// Shared encodings for the EXE stage: ALU opcode bits, mem_all/exc_rf bit positions,
// SRAM size codes and the data-request FSM states.
package exe_stage_pkg;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // mem_all = {mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w}
    localparam int MEM_WE = 7;
    localparam int LD_B   = 6;
    localparam int LD_H   = 5;
    localparam int LD_W   = 4;
    localparam int LD_SE  = 3;
    localparam int ST_B   = 2;
    localparam int ST_H   = 1;
    localparam int ST_W   = 0;

    // ID-side exc_rf = {INT, ADEF, BRK, INE, SYS, ertn}
    localparam int EXC6_INT  = 5;
    localparam int EXC6_ADEF = 4;
    localparam int EXC6_BRK  = 3;
    localparam int EXC6_INE  = 2;
    localparam int EXC6_SYS  = 1;
    localparam int EXC6_ERTN = 0;

    // EXE-side exc_rf = {INT, ADEF, ALE, BRK, INE, SYS, ertn}
    localparam int EXC7_INT  = 6;
    localparam int EXC7_ADEF = 5;
    localparam int EXC7_ALE  = 4;
    localparam int EXC7_BRK  = 3;
    localparam int EXC7_INE  = 2;
    localparam int EXC7_SYS  = 1;
    localparam int EXC7_ERTN = 0;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SENT = 2'd2
    } exe_state_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational LoongArch ALU with a one-hot opcode; result is the OR of the selected op.
module exe_stage_alu
    import exe_stage_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic        slt_res;
    logic        sltu_res;
    logic [4:0]  shamt;

    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
    assign sltu_res = alu_src1 < alu_src2;
    assign shamt    = alu_src2[4:0];

    always_comb begin
        alu_result = '0;
        if (alu_op[ALU_ADD])  alu_result = alu_result | add_res;
        if (alu_op[ALU_SUB])  alu_result = alu_result | sub_res;
        if (alu_op[ALU_SLT])  alu_result = alu_result | {31'b0, slt_res};
        if (alu_op[ALU_SLTU]) alu_result = alu_result | {31'b0, sltu_res};
        if (alu_op[ALU_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[ALU_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[ALU_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[ALU_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[ALU_SLL])  alu_result = alu_result | (alu_src1 << shamt);
        if (alu_op[ALU_SRL])  alu_result = alu_result | (alu_src1 >> shamt);
        if (alu_op[ALU_SRA])  alu_result = alu_result | 32'($signed(alu_src1) >>> shamt);
        if (alu_op[ALU_LUI])  alu_result = alu_result | alu_src2;
    end

endmodule

// File: rtl/exe_stage.sv
// LoongArch EXE stage: ALU, ALE detection, data-side SRAM-like request, orphan tracking for flushed requests.
// Latency 1 cycle (memory ops wait for addr_ok); mem_allowin=0 holds the bundle without re-issuing a request.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int ORPH_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_to_exe_valid,
    output logic        exe_allowin,
    input  logic [31:0] id_pc,
    input  logic [11:0] id_alu_op,
    input  logic [31:0] id_alu_src1,
    input  logic [31:0] id_alu_src2,
    input  logic [31:0] id_rkd_value,
    input  logic [7:0]  id_mem_all,
    input  logic        id_res_from_mem,
    input  logic [5:0]  id_rf_all,
    input  logic [78:0] id_csr_rf,
    input  logic [5:0]  id_exc_rf,
    input  logic        mem_allowin,
    output logic        exe_ready_go,
    output logic        exe_to_mem_valid,
    output logic [31:0] exe_pc,
    output logic [31:0] exe_result,
    output logic [31:0] exe_rkd_value,
    output logic [7:0]  exe_mem_all,
    output logic        exe_res_from_mem,
    output logic [5:0]  exe_rf_all,
    output logic [78:0] exe_csr_rf,
    output logic [6:0]  exe_exc_rf,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic        data_ok_discard,
    input  logic        mem_exc_flush,
    input  logic        wb_exc_flush,
    input  logic        cancel_exc_ertn
);

    logic              exe_valid;
    logic [11:0]       alu_op;
    logic [31:0]       alu_src1;
    logic [31:0]       alu_src2;
    logic [5:0]        exc6;
    exe_state_t        state;
    exe_state_t        state_nxt;
    logic [ORPH_W-1:0] orphan_cnt;

    logic is_ld;
    logic is_st;
    logic ale;
    logic no_req;
    logic req_first;
    logic accepted;
    logic leave;
    logic orph_inc;
    logic orph_dec;

    exe_stage_alu u_alu (
        .alu_op     (alu_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_result (exe_result)
    );

    assign is_ld = exe_mem_all[LD_B] | exe_mem_all[LD_H] | exe_mem_all[LD_W];
    assign is_st = exe_mem_all[ST_B] | exe_mem_all[ST_H] | exe_mem_all[ST_W];
    assign ale   = ((exe_mem_all[LD_H] | exe_mem_all[ST_H]) & exe_result[0])
                 | ((exe_mem_all[LD_W] | exe_mem_all[ST_W]) & (|exe_result[1:0]));

    always_comb begin
        exe_exc_rf            = '0;
        exe_exc_rf[EXC7_INT]  = exc6[EXC6_INT];
        exe_exc_rf[EXC7_ADEF] = exc6[EXC6_ADEF];
        exe_exc_rf[EXC7_ALE]  = ale;
        exe_exc_rf[EXC7_BRK]  = exc6[EXC6_BRK];
        exe_exc_rf[EXC7_INE]  = exc6[EXC6_INE];
        exe_exc_rf[EXC7_SYS]  = exc6[EXC6_SYS];
        exe_exc_rf[EXC7_ERTN] = exc6[EXC6_ERTN];
    end

    assign no_req = ~(is_ld | is_st) | (|exe_exc_rf) | mem_exc_flush | wb_exc_flush;

    // The request is raised combinationally in the instruction's first cycle so that
    // a same-cycle addr_ok completes in one cycle; once raised it is never retracted.
    assign req_first     = exe_valid & ~no_req & (state == S_IDLE);
    assign data_sram_req = (state == S_REQ) | req_first;
    assign accepted      = data_sram_req & data_sram_addr_ok;

    always_comb begin
        exe_ready_go = 1'b0;
        case (state)
            S_IDLE:  exe_ready_go = no_req | accepted;
            S_REQ:   exe_ready_go = data_sram_addr_ok;
            S_SENT:  exe_ready_go = 1'b1;
            default: exe_ready_go = 1'b0;
        endcase
    end

    assign exe_to_mem_valid = exe_valid & exe_ready_go;
    assign leave            = exe_to_mem_valid & mem_allowin;
    // A cancelled request still waiting for addr_ok owns the bundle regs, so block ID.
    assign exe_allowin      = exe_valid ? (exe_ready_go & mem_allowin)
                                        : ((state != S_REQ) | data_sram_addr_ok);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_first) begin
                if (!data_sram_addr_ok)            state_nxt = S_REQ;
                else if (cancel_exc_ertn || leave) state_nxt = S_IDLE;
                else                               state_nxt = S_SENT;
            end
            S_REQ: if (data_sram_addr_ok) begin
                if (cancel_exc_ertn || !exe_valid || leave) state_nxt = S_IDLE;
                else                                        state_nxt = S_SENT;
            end
            S_SENT: if (cancel_exc_ertn || leave) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    assign orph_inc = (accepted & (cancel_exc_ertn | ~exe_valid))
                    | ((state == S_SENT) & cancel_exc_ertn);
    assign orph_dec = data_sram_data_ok & (orphan_cnt != '0);
    assign data_ok_discard = orphan_cnt != '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            orphan_cnt <= '0;
        end else if (orph_inc && !orph_dec) begin
            if (orphan_cnt != '1) orphan_cnt <= orphan_cnt + 1'b1;
        end else if (orph_dec && !orph_inc) begin
            orphan_cnt <= orphan_cnt - 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (!resetn)
                     !(orph_inc && !orph_dec && (&orphan_cnt)));

    always_ff @(posedge clk) begin
        if (!resetn)                exe_valid <= 1'b0;
        else if (cancel_exc_ertn)   exe_valid <= 1'b0;
        else if (exe_allowin)       exe_valid <= id_to_exe_valid;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            exe_pc           <= '0;
            alu_op           <= '0;
            alu_src1         <= '0;
            alu_src2         <= '0;
            exe_rkd_value    <= '0;
            exe_mem_all      <= '0;
            exe_res_from_mem <= 1'b0;
            exe_rf_all       <= '0;
            exe_csr_rf       <= '0;
            exc6             <= '0;
        end else if (exe_allowin && id_to_exe_valid) begin
            exe_pc           <= id_pc;
            alu_op           <= id_alu_op;
            alu_src1         <= id_alu_src1;
            alu_src2         <= id_alu_src2;
            exe_rkd_value    <= id_rkd_value;
            exe_mem_all      <= id_mem_all;
            exe_res_from_mem <= id_res_from_mem;
            exe_rf_all       <= id_rf_all;
            exe_csr_rf       <= id_csr_rf;
            exc6             <= id_exc_rf;
        end
    end

    assign data_sram_wr   = exe_mem_all[MEM_WE];
    assign data_sram_addr = exe_result;

    always_comb begin
        data_sram_size  = SIZE_W;
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = exe_rkd_value;
        if (exe_mem_all[LD_B] || exe_mem_all[ST_B])      data_sram_size = SIZE_B;
        else if (exe_mem_all[LD_H] || exe_mem_all[ST_H]) data_sram_size = SIZE_H;
        if (exe_mem_all[ST_B]) begin
            data_sram_wstrb = 4'b0001 << exe_result[1:0];
            data_sram_wdata = {4{exe_rkd_value[7:0]}};
        end else if (exe_mem_all[ST_H]) begin
            data_sram_wstrb = exe_result[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{exe_rkd_value[15:0]}};
        end else if (exe_mem_all[ST_W]) begin
            data_sram_wstrb = 4'b1111;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU pass, store lanes, ALE, addr_ok stalls, flush/orphan handling, back-pressure.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_to_exe_valid;
    logic        exe_allowin;
    logic [31:0] id_pc;
    logic [11:0] id_alu_op;
    logic [31:0] id_alu_src1;
    logic [31:0] id_alu_src2;
    logic [31:0] id_rkd_value;
    logic [7:0]  id_mem_all;
    logic        id_res_from_mem;
    logic [5:0]  id_rf_all;
    logic [78:0] id_csr_rf;
    logic [5:0]  id_exc_rf;
    logic        mem_allowin;
    logic        exe_ready_go;
    logic        exe_to_mem_valid;
    logic [31:0] exe_pc;
    logic [31:0] exe_result;
    logic [31:0] exe_rkd_value;
    logic [7:0]  exe_mem_all;
    logic        exe_res_from_mem;
    logic [5:0]  exe_rf_all;
    logic [78:0] exe_csr_rf;
    logic [6:0]  exe_exc_rf;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic        data_ok_discard;
    logic        mem_exc_flush;
    logic        wb_exc_flush;
    logic        cancel_exc_ertn;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [11:0] OP_SUB = 12'h002;
    localparam logic [7:0]  M_LDW  = 8'h10;
    localparam logic [7:0]  M_LDH  = 8'h28;
    localparam logic [7:0]  M_STB  = 8'h84;
    localparam logic [7:0]  M_STH  = 8'h82;
    localparam logic [7:0]  M_STW  = 8'h81;

    exe_stage #(.ORPH_W(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .id_to_exe_valid   (id_to_exe_valid),
        .exe_allowin       (exe_allowin),
        .id_pc             (id_pc),
        .id_alu_op         (id_alu_op),
        .id_alu_src1       (id_alu_src1),
        .id_alu_src2       (id_alu_src2),
        .id_rkd_value      (id_rkd_value),
        .id_mem_all        (id_mem_all),
        .id_res_from_mem   (id_res_from_mem),
        .id_rf_all         (id_rf_all),
        .id_csr_rf         (id_csr_rf),
        .id_exc_rf         (id_exc_rf),
        .mem_allowin       (mem_allowin),
        .exe_ready_go      (exe_ready_go),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .exe_pc            (exe_pc),
        .exe_result        (exe_result),
        .exe_rkd_value     (exe_rkd_value),
        .exe_mem_all       (exe_mem_all),
        .exe_res_from_mem  (exe_res_from_mem),
        .exe_rf_all        (exe_rf_all),
        .exe_csr_rf        (exe_csr_rf),
        .exe_exc_rf        (exe_exc_rf),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_ok_discard   (data_ok_discard),
        .mem_exc_flush     (mem_exc_flush),
        .wb_exc_flush      (wb_exc_flush),
        .cancel_exc_ertn   (cancel_exc_ertn)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single cycle; returns at posedge+2 with it in EXE.
    task automatic issue(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] rkd, input logic [7:0] mall);
        id_to_exe_valid = 1'b1;
        id_pc           = id_pc + 32'd4;
        id_alu_op       = op;
        id_alu_src1     = s1;
        id_alu_src2     = s2;
        id_rkd_value    = rkd;
        id_mem_all      = mall;
        id_res_from_mem = |mall[6:4];
        tick();
        id_to_exe_valid = 1'b0;
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        id_to_exe_valid = 1'b0;
        id_pc = 32'h1c00_0000;
        id_alu_op = '0;
        id_alu_src1 = '0;
        id_alu_src2 = '0;
        id_rkd_value = '0;
        id_mem_all = '0;
        id_res_from_mem = 1'b0;
        id_rf_all = 6'h25;
        id_csr_rf = {15'h1234, 64'hcafe_f00d_0bad_beef};
        id_exc_rf = '0;
        mem_allowin = 1'b1;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        mem_exc_flush = 1'b0;
        wb_exc_flush = 1'b0;
        cancel_exc_ertn = 1'b0;

        tick();
        tick();
        chk("rst_to_mem_valid", exe_to_mem_valid, 1'b0);
        chk("rst_req", data_sram_req, 1'b0);
        chk("rst_discard", data_ok_discard, 1'b0);
        chk("rst_allowin", exe_allowin, 1'b1);
        chk("rst_result", exe_result, 32'h0);
        chk("rst_exc", exe_exc_rf, 7'h00);
        resetn = 1'b1;
        tick();

        // add 3+4
        issue(OP_ADD, 32'd3, 32'd4, 32'd0, 8'h00);
        chk("add_to_mem_valid", exe_to_mem_valid, 1'b1);
        chk("add_result", exe_result, 32'd7);
        chk("add_req", data_sram_req, 1'b0);
        chk("add_pc", exe_pc, 32'h1c00_0004);
        chk("add_csr", exe_csr_rf, {15'h1234, 64'hcafe_f00d_0bad_beef});
        chk("add_rf_all", exe_rf_all, 6'h25);
        tick();
        chk("add_gone", exe_to_mem_valid, 1'b0);
        chk("add_req_after", data_sram_req, 1'b0);

        // sub with INT+SYS from ID: ALE bit inserted at position 4
        id_exc_rf = 6'b100010;
        issue(OP_SUB, 32'd3, 32'd4, 32'd0, 8'h00);
        id_exc_rf = '0;
        chk("sub_result", exe_result, 32'hffff_ffff);
        chk("sub_exc", exe_exc_rf, 7'b1000010);
        tick();

        // st.b at 0x1003, same-cycle addr_ok
        issue(OP_ADD, 32'h1000, 32'h3, 32'h1234_5678, M_STB);
        chk("stb_req", data_sram_req, 1'b1);
        chk("stb_wr", data_sram_wr, 1'b1);
        chk("stb_size", data_sram_size, 2'd0);
        chk("stb_wstrb", data_sram_wstrb, 4'b1000);
        chk("stb_wdata", data_sram_wdata, 32'h7878_7878);
        chk("stb_addr", data_sram_addr, 32'h1003);
        chk("stb_rdy_before_ok", exe_ready_go, 1'b0);
        data_sram_addr_ok = 1'b1;
        #1;
        chk("stb_ready_go", exe_ready_go, 1'b1);
        chk("stb_to_mem", exe_to_mem_valid, 1'b1);
        tick();
        data_sram_addr_ok = 1'b0;
        #1;
        chk("stb_req_after", data_sram_req, 1'b0);

        // st.h at 0x1002
        issue(OP_ADD, 32'h1000, 32'h2, 32'h1234_5678, M_STH);
        chk("sth_wstrb", data_sram_wstrb, 4'b1100);
        chk("sth_wdata", data_sram_wdata, 32'h5678_5678);
        chk("sth_size", data_sram_size, 2'd1);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;

        // st.h misaligned
        issue(OP_ADD, 32'h1000, 32'h1, 32'h0, M_STH);
        chk("sth_ale_exc", exe_exc_rf, 7'b0010000);
        chk("sth_ale_req", data_sram_req, 1'b0);
        tick();

        // ld.w at 0x1002 -> ALE, no request, passes to MEM
        issue(OP_ADD, 32'h1000, 32'h2, 32'h0, M_LDW);
        chk("ldw_ale_exc", exe_exc_rf, 7'b0010000);
        chk("ldw_ale_req", data_sram_req, 1'b0);
        chk("ldw_ale_to_mem", exe_to_mem_valid, 1'b1);
        chk("ldw_res_from_mem", exe_res_from_mem, 1'b1);
        tick();
        chk("ldw_ale_req_after", data_sram_req, 1'b0);

        // ld.h at 0x2002, addr_ok delayed 3 cycles
        issue(OP_ADD, 32'h2000, 32'h2, 32'h0, M_LDH);
        for (int c = 0; c < 3; c++) begin
            chk("ldh_wait_req", data_sram_req, 1'b1);
            chk("ldh_wait_addr", data_sram_addr, 32'h2002);
            chk("ldh_wait_size", data_sram_size, 2'd1);
            chk("ldh_wait_rdy", exe_ready_go, 1'b0);
            tick();
        end
        chk("ldh_wstrb", data_sram_wstrb, 4'b0000);
        chk("ldh_wr", data_sram_wr, 1'b0);
        data_sram_addr_ok = 1'b1;
        #1;
        chk("ldh_req_c4", data_sram_req, 1'b1);
        chk("ldh_ready_c4", exe_ready_go, 1'b1);
        tick();
        data_sram_addr_ok = 1'b0;
        #1;
        chk("ldh_req_done", data_sram_req, 1'b0);

        // ld.w pending in REQ, cancel, addr_ok two cycles later -> orphan
        issue(OP_ADD, 32'h3000, 32'h0, 32'h0, M_LDW);
        tick();
        cancel_exc_ertn = 1'b1;
        #1;
        chk("orph_req_at_cancel", data_sram_req, 1'b1);
        chk("orph_to_mem_at_cancel", exe_to_mem_valid, 1'b0);
        tick();
        cancel_exc_ertn = 1'b0;
        #1;
        chk("orph_req_held", data_sram_req, 1'b1);
        chk("orph_addr_held", data_sram_addr, 32'h3000);
        chk("orph_allowin_blocked", exe_allowin, 1'b0);
        chk("orph_to_mem_held", exe_to_mem_valid, 1'b0);
        tick();
        data_sram_addr_ok = 1'b1;
        #1;
        chk("orph_req_at_ok", data_sram_req, 1'b1);
        chk("orph_discard_pre", data_ok_discard, 1'b0);
        tick();
        data_sram_addr_ok = 1'b0;
        #1;
        chk("orph_discard_1", data_ok_discard, 1'b1);
        chk("orph_req_dropped", data_sram_req, 1'b0);
        tick();
        chk("orph_discard_2", data_ok_discard, 1'b1);
        data_sram_data_ok = 1'b1;
        #1;
        chk("orph_discard_dok", data_ok_discard, 1'b1);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("orph_discard_clr", data_ok_discard, 1'b0);

        // st.w while MEM holds an exception
        mem_exc_flush = 1'b1;
        issue(OP_ADD, 32'h4000, 32'h0, 32'haaaa_5555, M_STW);
        chk("flush_req", data_sram_req, 1'b0);
        chk("flush_ready_go", exe_ready_go, 1'b1);
        chk("flush_to_mem", exe_to_mem_valid, 1'b1);
        tick();
        mem_exc_flush = 1'b0;
        #1;
        chk("flush_req_after", data_sram_req, 1'b0);

        // st.w accepted while MEM stalls: held in EXE, not re-issued
        mem_allowin = 1'b0;
        issue(OP_ADD, 32'h5000, 32'h0, 32'hdead_beef, M_STW);
        chk("bp_wstrb", data_sram_wstrb, 4'b1111);
        chk("bp_wdata", data_sram_wdata, 32'hdead_beef);
        data_sram_addr_ok = 1'b1;
        #1;
        chk("bp_allowin_ok", exe_allowin, 1'b0);
        tick();
        data_sram_addr_ok = 1'b0;
        #1;
        chk("bp_no_reissue", data_sram_req, 1'b0);
        chk("bp_ready_go", exe_ready_go, 1'b1);
        chk("bp_to_mem", exe_to_mem_valid, 1'b1);
        chk("bp_allowin", exe_allowin, 1'b0);
        tick();
        chk("bp_no_reissue2", data_sram_req, 1'b0);
        mem_allowin = 1'b1;
        #1;
        chk("bp_allowin_rel", exe_allowin, 1'b1);
        tick();
        chk("bp_gone", exe_to_mem_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
